// File: rtl/crc32_pkg.sv
// crc32_pkg -- shared constants, types and helpers for the CRC-32 blocks.
//   CRC32_POLY      reflected IEEE polynomial
//   CRC32_INIT      CRC register value at the start of a frame
//   CRC32_RESIDUE   register value left after a good frame plus its FCS
//   CRC32_NIB_TABLE 16-entry nibble table for the reflected polynomial
//   crc32_state_e   receiver FSM states
//   crc32_nibble_step() one 4-bit fold of the CRC register
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // T[i] = four LSB-first shift/xor steps of the value i.
  localparam logic [31:0] CRC32_NIB_TABLE [16] = '{
    32'h00000000, 32'h1DB71064, 32'h3B6E20C8, 32'h26D930AC,
    32'h76DC4190, 32'h6B6B51F4, 32'h4DB26158, 32'h5005713C,
    32'hEDB88320, 32'hF00F9344, 32'hD6D6A3E8, 32'hCB61B38C,
    32'h9B64C2B0, 32'h86D3D2D4, 32'hA00AE278, 32'hBDBDF21C
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } crc32_state_e;

  function automatic logic [31:0] crc32_nibble_step(input logic [31:0] crc,
                                                    input logic [3:0]  nib);
    logic [3:0] idx;
    idx = crc[3:0] ^ nib;
    return (crc >> 4) ^ CRC32_NIB_TABLE[idx];
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// crc32_byte_step -- combinational fold of one byte into a reflected CRC-32.
// The byte is consumed as two nibble steps, low nibble first, which is the
// on-air bit order for an LSB-first byte.
//   crc_in  [31:0]  CRC register before the byte
//   byte_in [7:0]   byte to fold
//   crc_nxt [31:0]  CRC register after the byte
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_nxt
);

  logic [31:0] crc_lo;

  assign crc_lo  = crc32_nibble_step(crc_in, byte_in[3:0]);
  assign crc_nxt = crc32_nibble_step(crc_lo, byte_in[7:4]);

endmodule

// File: rtl/crc32_rx.sv
// crc32_rx -- receive-side CRC-32 checker with frame length policing.
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_data  byte stream, one byte per cycle when s_valid=1
//   s_last          final byte of a frame (only meaningful with s_valid)
//   abort           drops the frame in progress without a result
//   busy            high while a frame is in progress
//   crc_out         running CRC register (not complemented)
//   frame_len       byte count of the last reported frame
//   fcs_valid       one-cycle result strobe, the cycle after the s_last byte
//   fcs_ok/len_err  frame result flags, held until the next result
module crc32_rx
  import crc32_pkg::*;
#(
  parameter int MIN_BYTES = 14,
  parameter int MAX_BYTES = 11454,
  parameter int LEN_W     = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             abort,
  output logic             busy,
  output logic [31:0]      crc_out,
  output logic [LEN_W-1:0] frame_len,
  output logic             fcs_valid,
  output logic             fcs_ok,
  output logic             len_err
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  crc32_state_e     state_reg;
  logic             busy_reg;
  logic [31:0]      crc_reg;
  logic [LEN_W-1:0] count_reg;
  logic [LEN_W-1:0] frame_len_reg;
  logic             fcs_valid_reg;
  logic             fcs_ok_reg;
  logic             len_err_reg;

  logic [31:0]      crc_base;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] count_next;
  logic [31:0]      count_ext;
  logic             len_err_next;
  logic             fcs_ok_next;

  // A byte seen in IDLE always opens a fresh frame, so the fold starts from
  // the init value rather than from whatever the last frame left behind.
  assign crc_base = (state_reg == IDLE) ? CRC32_INIT : crc_reg;

  crc32_byte_step u_byte_step (
    .crc_in  (crc_base),
    .byte_in (s_data),
    .crc_nxt (crc_next)
  );

  // Counter saturates instead of wrapping so oversize frames stay flagged.
  always_comb begin
    count_next = CNT_ONE;
    if (state_reg == RUN) begin
      count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_ONE;
    end
  end

  assign count_ext    = 32'(count_next);
  assign len_err_next = (count_ext < 32'(MIN_BYTES)) | (count_ext > 32'(MAX_BYTES));
  assign fcs_ok_next  = (crc_next == CRC32_RESIDUE) & ~len_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      crc_reg       <= CRC32_INIT;
      count_reg     <= '0;
      frame_len_reg <= '0;
      fcs_valid_reg <= 1'b0;
      fcs_ok_reg    <= 1'b0;
      len_err_reg   <= 1'b0;
    end else begin
      fcs_valid_reg <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else if (s_valid) begin
        crc_reg   <= crc_next;
        count_reg <= count_next;
        if (s_last) begin
          // Result is computed from the post-fold values so the strobe lands
          // exactly one cycle after the last byte.
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          fcs_valid_reg <= 1'b1;
          frame_len_reg <= count_next;
          len_err_reg   <= len_err_next;
          fcs_ok_reg    <= fcs_ok_next;
        end else begin
          state_reg <= RUN;
          busy_reg  <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign crc_out   = crc_reg;
  assign frame_len = frame_len_reg;
  assign fcs_valid = fcs_valid_reg;
  assign fcs_ok    = fcs_ok_reg;
  assign len_err   = len_err_reg;

endmodule

// File: tb/tb_crc32_rx.sv
// tb_crc32_rx -- directed bench for crc32_rx. Four instances share one input
// stream: default parameters, MIN_BYTES=4, MIN_BYTES=4/MAX_BYTES=16, and a
// 4-bit counter variant (MAX_BYTES=12) that exercises saturation.
module tb_crc32_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       abort;

  // default parameters
  logic        d_busy, d_fv, d_ok, d_le;
  logic [31:0] d_crc;
  logic [13:0] d_len;
  // MIN_BYTES=4
  logic        m_busy, m_fv, m_ok, m_le;
  logic [31:0] m_crc;
  logic [13:0] m_len;
  // MIN_BYTES=4, MAX_BYTES=16
  logic        x_busy, x_fv, x_ok, x_le;
  logic [31:0] x_crc;
  logic [13:0] x_len;
  // LEN_W=4, MIN_BYTES=4, MAX_BYTES=12
  logic        t_busy, t_fv, t_ok, t_le;
  logic [31:0] t_crc;
  logic [3:0]  t_len;

  crc32_rx dut_def (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .abort(abort), .busy(d_busy), .crc_out(d_crc), .frame_len(d_len),
    .fcs_valid(d_fv), .fcs_ok(d_ok), .len_err(d_le)
  );

  crc32_rx #(.MIN_BYTES(4)) dut_min (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .abort(abort), .busy(m_busy), .crc_out(m_crc), .frame_len(m_len),
    .fcs_valid(m_fv), .fcs_ok(m_ok), .len_err(m_le)
  );

  crc32_rx #(.MIN_BYTES(4), .MAX_BYTES(16)) dut_max (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .abort(abort), .busy(x_busy), .crc_out(x_crc), .frame_len(x_len),
    .fcs_valid(x_fv), .fcs_ok(x_ok), .len_err(x_le)
  );

  crc32_rx #(.MIN_BYTES(4), .MAX_BYTES(12), .LEN_W(4)) dut_sat (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .abort(abort), .busy(t_busy), .crc_out(t_crc), .frame_len(t_len),
    .fcs_valid(t_fv), .fcs_ok(t_ok), .len_err(t_le)
  );

  // "123456789" followed by its FCS 0xCBF43926, LSB first
  logic [7:0] good_frame [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                  8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor on the MIN_BYTES=4 instance
  int   pulse_cnt      = 0;
  int   pulse_cyc      = 0;
  int   prev_pulse_cyc = 0;
  logic pulse_ok       = 1'b0;
  logic prev_pulse_ok  = 1'b0;
  always @(negedge clk) begin
    if (m_fv) begin
      pulse_cnt      <= pulse_cnt + 1;
      prev_pulse_cyc <= pulse_cyc;
      pulse_cyc      <= cyc;
      prev_pulse_ok  <= pulse_ok;
      pulse_ok       <= m_ok;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] last_fcs);
    for (int i = 0; i < 13; i++) begin
      send_byte((i == 12) ? last_fcs : good_frame[i], (i == 12));
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int base;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; abort = 1'b0;
    tick(); tick();

    check_val("rst_busy", {31'b0, m_busy}, 32'd0);
    check_val("rst_crc", m_crc, 32'hFFFFFFFF);
    check_val("rst_len", {18'b0, m_len}, 32'd0);
    check_val("rst_fv", {31'b0, m_fv}, 32'd0);
    check_val("rst_ok_le", {30'b0, m_ok, m_le}, 32'd0);
    rst = 1'b0;
    idle(2);
    $display("[TB] reset done at cycle %0d", cyc);

    // Good 13-byte frame: too short for default params, good with MIN_BYTES=4
    send_good(8'hCB);
    check_val("def_fv", {31'b0, d_fv}, 32'd1);
    check_val("def_crc", d_crc, 32'hDEBB20E3);
    check_val("def_len", {18'b0, d_len}, 32'd13);
    check_val("def_le", {31'b0, d_le}, 32'd1);
    check_val("def_ok", {31'b0, d_ok}, 32'd0);
    check_val("min_fv", {31'b0, m_fv}, 32'd1);
    check_val("min_ok", {31'b0, m_ok}, 32'd1);
    check_val("min_le", {31'b0, m_le}, 32'd0);
    check_val("min_busy_end", {31'b0, m_busy}, 32'd0);
    idle(1);
    check_val("min_fv_one_cycle", {31'b0, m_fv}, 32'd0);
    idle(3);
    check_val("hold_len", {18'b0, m_len}, 32'd13);
    check_val("hold_ok", {31'b0, m_ok}, 32'd1);
    check_val("hold_crc", m_crc, 32'hDEBB20E3);
    $display("[TB] good frame done at cycle %0d", cyc);

    // Corrupted FCS
    send_good(8'hCA);
    check_val("bad_fv", {31'b0, m_fv}, 32'd1);
    check_val("bad_ok", {31'b0, m_ok}, 32'd0);
    check_val("bad_le", {31'b0, m_le}, 32'd0);
    idle(2);
    $display("[TB] bad-fcs frame done at cycle %0d", cyc);

    // One-byte frame of 0x00 straight from IDLE
    send_byte(8'h00, 1'b1);
    check_val("one_fv", {31'b0, m_fv}, 32'd1);
    check_val("one_crc", m_crc, 32'h2DFD1072);
    check_val("one_len", {18'b0, m_len}, 32'd1);
    check_val("one_le", {31'b0, m_le}, 32'd1);
    check_val("one_busy", {31'b0, m_busy}, 32'd0);
    idle(2);
    $display("[TB] one-byte frame done at cycle %0d", cyc);

    // s_last without s_valid mid-frame is ignored
    for (int i = 0; i < 5; i++) send_byte(good_frame[i], 1'b0);
    s_last = 1'b1;
    tick();
    s_last = 1'b0;
    check_val("stray_last_fv", {31'b0, m_fv}, 32'd0);
    check_val("stray_last_busy", {31'b0, m_busy}, 32'd1);
    for (int i = 5; i < 13; i++) send_byte(good_frame[i], (i == 12));
    check_val("stray_last_len", {18'b0, m_len}, 32'd13);
    check_val("stray_last_ok", {31'b0, m_ok}, 32'd1);
    idle(2);
    $display("[TB] stray s_last frame done at cycle %0d", cyc);

    // Back-to-back frames
    base = pulse_cnt;
    send_good(8'hCB);
    send_good(8'hCB);
    idle(2);
    check_val("b2b_pulses", pulse_cnt - base, 32'd2);
    check_val("b2b_spacing", pulse_cyc - prev_pulse_cyc, 32'd13);
    check_val("b2b_ok", {30'b0, prev_pulse_ok, pulse_ok}, 32'd3);
    $display("[TB] back-to-back frames done at cycle %0d", cyc);

    // Abort on byte 6 (with s_valid high), then a good frame
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) send_byte(good_frame[i], 1'b0);
    abort = 1'b1; s_valid = 1'b1; s_data = good_frame[5]; s_last = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check_val("abort_busy", {31'b0, m_busy}, 32'd0);
    idle(1);
    check_val("abort_fv", {31'b0, m_fv}, 32'd0);
    send_good(8'hCB);
    idle(2);
    check_val("abort_pulses", pulse_cnt - base, 32'd1);
    check_val("abort_ok", {31'b0, m_ok}, 32'd1);
    check_val("abort_len", {18'b0, m_len}, 32'd13);
    $display("[TB] abort + good frame done at cycle %0d", cyc);

    // Reset on byte 8, then a 20-byte frame
    base = pulse_cnt;
    for (int i = 0; i < 7; i++) send_byte(good_frame[i], 1'b0);
    rst = 1'b1; s_valid = 1'b1; s_data = good_frame[7];
    tick();
    rst = 1'b0; s_valid = 1'b0;
    check_val("rstmid_busy", {31'b0, m_busy}, 32'd0);
    check_val("rstmid_crc", m_crc, 32'hFFFFFFFF);
    idle(2);
    check_val("rstmid_pulses", pulse_cnt - base, 32'd0);
    for (int i = 0; i < 20; i++) send_byte(8'(i * 7 + 3), (i == 19));
    check_val("long_max_fv", {31'b0, x_fv}, 32'd1);
    check_val("long_max_le", {31'b0, x_le}, 32'd1);
    check_val("long_max_len", {18'b0, x_len}, 32'd20);
    check_val("long_max_ok", {31'b0, x_ok}, 32'd0);
    check_val("long_def_len", {18'b0, d_len}, 32'd20);
    check_val("long_def_le", {31'b0, d_le}, 32'd0);
    check_val("sat_len", {28'b0, t_len}, 32'd15);
    check_val("sat_le", {31'b0, t_le}, 32'd1);
    idle(2);
    check_val("long_pulses", pulse_cnt - base, 32'd1);
    $display("[TB] reset frame + 20-byte frame done at cycle %0d", cyc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
